// File: rtl/uart_tx_rx.sv
// ---------------------------------------------------------------------------
// uart_tx_rx -- 8N1 UART transmitter and receiver sharing one baud select.
//
// Parameters
//   CLK_FREQ      clock frequency in Hz; bit period DIV = CLK_FREQ / baud
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   baud_set      baud select 0..4 = 9600/19200/38400/57600/115200, 5..7 = 9600
//   data_byte     TX payload, captured when send_en is accepted
//   send_en       one-cycle TX start request, ignored while TX is busy
//   rs232_tx      serial TX line, idle high
//   tx_done       one-cycle pulse at the end of the stop bit
//   uart_state    TX busy flag
//   bps_clk       one-cycle pulse at the last cycle of every TX bit
//   rs232_rx      asynchronous serial RX line
//   rx_data_byte  last byte received with a valid stop bit
//   rx_done       one-cycle pulse when rx_data_byte has been updated
// ---------------------------------------------------------------------------
module uart_tx_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_set,
  input  logic [7:0] data_byte,
  input  logic       send_en,
  output logic       rs232_tx,
  output logic       tx_done,
  output logic       uart_state,
  output logic       bps_clk,
  input  logic       rs232_rx,
  output logic [7:0] rx_data_byte,
  output logic       rx_done
);

  // The slowest rate sets the counter width.
  localparam int unsigned DIV_MAX = CLK_FREQ / 9600;
  localparam int unsigned CW      = $clog2(DIV_MAX + 1);
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} frame_state_t;

  function automatic cnt_t div_of(input logic [2:0] sel);
    case (sel)
      3'd1:    div_of = cnt_t'(CLK_FREQ / 19200);
      3'd2:    div_of = cnt_t'(CLK_FREQ / 38400);
      3'd3:    div_of = cnt_t'(CLK_FREQ / 57600);
      3'd4:    div_of = cnt_t'(CLK_FREQ / 115200);
      default: div_of = cnt_t'(CLK_FREQ / 9600);
    endcase
  endfunction

  cnt_t w_div_sel;
  assign w_div_sel = div_of(baud_set);

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  frame_state_t r_tx_state;
  cnt_t         r_tx_div;
  cnt_t         r_tx_cnt;
  logic [2:0]   r_tx_bit;
  logic [7:0]   r_tx_shift;
  logic         r_tx_line;
  logic         r_tx_busy;
  logic         r_tx_done;
  logic         r_tx_bps;
  logic         w_tx_bit_end;
  logic         w_tx_pre_end;

  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - cnt_t'(1));
  assign w_tx_pre_end = (r_tx_cnt == r_tx_div - cnt_t'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_div   <= '0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_bps   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the
      // pre-edge value of every other one regardless of statement order; the
      // pulse defaults below are simply overridden later in the block.
      r_tx_done <= 1'b0;
      r_tx_bps  <= 1'b0;
      if (r_tx_state == S_IDLE) begin
        r_tx_cnt <= '0;
        // The tx_done cycle itself is still part of the finished frame.
        if (send_en && !r_tx_done) begin
          r_tx_state <= S_START;
          r_tx_div   <= w_div_sel;
          r_tx_shift <= data_byte;
          r_tx_line  <= 1'b0;
          r_tx_bit   <= '0;
          r_tx_busy  <= 1'b1;
        end
      end else begin
        // Registered one cycle ahead so the tick lands on count DIV-1.
        r_tx_bps <= w_tx_pre_end;
        if (r_tx_state == S_STOP && w_tx_pre_end) begin
          // Leave one cycle early: tx_done, the 10th tick and the idle flag
          // all appear in the last cycle of the stop bit.
          r_tx_state <= S_IDLE;
          r_tx_busy  <= 1'b0;
          r_tx_done  <= 1'b1;
          r_tx_cnt   <= '0;
        end else if (w_tx_bit_end) begin
          r_tx_cnt <= '0;
          case (r_tx_state)
            S_START: begin
              r_tx_state <= S_DATA;
              r_tx_line  <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= '0;
            end
            S_DATA: begin
              if (r_tx_bit == 3'd7) begin
                r_tx_state <= S_STOP;
                r_tx_line  <= 1'b1;
              end else begin
                r_tx_line  <= r_tx_shift[0];
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bit   <= r_tx_bit + 3'd1;
              end
            end
            default: ;
          endcase
        end else begin
          r_tx_cnt <= r_tx_cnt + cnt_t'(1);
        end
      end
    end
  end

  assign rs232_tx   = r_tx_line;
  assign tx_done    = r_tx_done;
  assign uart_state = r_tx_busy;
  assign bps_clk    = r_tx_bps;

  // -------------------------------------------------------------------------
  // Receiver
  // -------------------------------------------------------------------------
  frame_state_t r_rx_state;
  cnt_t         r_rx_div;
  cnt_t         r_rx_cnt;
  logic [2:0]   r_rx_bit;
  logic [7:0]   r_rx_shift;
  logic [7:0]   r_rx_data;
  logic [1:0]   r_rx_ones;
  logic         r_rx_meta;
  logic         r_rx_sync;
  logic         r_rx_prev;
  logic         r_rx_done;
  cnt_t         w_rx_half;
  logic [1:0]   w_rx_votes;
  logic         w_rx_maj;
  logic         w_rx_fall;
  logic         w_rx_bit_end;
  logic         w_rx_decide;

  // r_rx_cnt is the offset from the start of the current bit; the falling
  // edge detect cycle is offset 0 of the start bit.
  assign w_rx_half    = r_rx_div >> 1;
  assign w_rx_votes   = r_rx_ones + {1'b0, r_rx_sync};
  assign w_rx_maj     = w_rx_votes[1];
  assign w_rx_fall    = r_rx_prev & ~r_rx_sync;
  assign w_rx_bit_end = (r_rx_cnt == r_rx_div - cnt_t'(1));
  assign w_rx_decide  = (r_rx_cnt == w_rx_half + cnt_t'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer resets to the idle level so reset release is not an edge.
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_div   <= '0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_ones  <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_meta <= rs232_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_rx_done <= 1'b0;
      if (r_rx_state == S_IDLE) begin
        if (w_rx_fall) begin
          r_rx_state <= S_START;
          r_rx_div   <= w_div_sel;
          r_rx_cnt   <= cnt_t'(1);
          r_rx_bit   <= '0;
          r_rx_ones  <= '0;
        end
      end else begin
        if (w_rx_bit_end) r_rx_cnt <= '0;
        else              r_rx_cnt <= r_rx_cnt + cnt_t'(1);

        // First two of the three mid-bit samples; the third is folded in
        // combinationally at the decision offset.
        if (r_rx_cnt == w_rx_half - cnt_t'(1)) r_rx_ones <= {1'b0, r_rx_sync};
        else if (r_rx_cnt == w_rx_half)        r_rx_ones <= w_rx_votes;

        case (r_rx_state)
          S_START: begin
            if (w_rx_decide && w_rx_maj) r_rx_state <= S_IDLE;
            else if (w_rx_bit_end)       r_rx_state <= S_DATA;
          end
          S_DATA: begin
            if (w_rx_decide) r_rx_shift <= {w_rx_maj, r_rx_shift[7:1]};
            if (w_rx_bit_end) begin
              if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
              else                  r_rx_bit   <= r_rx_bit + 3'd1;
            end
          end
          S_STOP: begin
            // Back to idle mid-stop-bit so a following start edge is caught.
            if (w_rx_decide) begin
              r_rx_state <= S_IDLE;
              if (w_rx_maj) begin
                r_rx_data <= r_rx_shift;
                r_rx_done <= 1'b1;
              end
            end
          end
          default: r_rx_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_data_byte = r_rx_data;
  assign rx_done      = r_rx_done;

endmodule

// File: tb/tb_uart_tx_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_rx -- self-checking bench for uart_tx_rx.
// The DUT runs at a reduced CLK_FREQ so several frames fit in a short run;
// all expected timing is derived from DIV = CLK_FREQ / baud.
// ---------------------------------------------------------------------------
module tb_uart_tx_rx;

  localparam int unsigned CLK_HZ = 2_000_000;

  logic       clk;
  logic       rst;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       send_en;
  logic       rs232_tx;
  logic       tx_done;
  logic       uart_state;
  logic       bps_clk;
  logic       rs232_rx;
  logic [7:0] rx_data_byte;
  logic       rx_done;

  logic       loop_en;
  logic       rx_drive;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_rx;   // byte the receiver is expected to be holding

  assign rs232_rx = loop_en ? rs232_tx : rx_drive;

  uart_tx_rx #(.CLK_FREQ(CLK_HZ)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_set     (baud_set),
    .data_byte    (data_byte),
    .send_en      (send_en),
    .rs232_tx     (rs232_tx),
    .tx_done      (tx_done),
    .uart_state   (uart_state),
    .bps_clk      (bps_clk),
    .rs232_rx     (rs232_rx),
    .rx_data_byte (rx_data_byte),
    .rx_done      (rx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_div(input logic [2:0] b);
    int baud;
    case (b)
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return CLK_HZ / baud;
  endfunction

  // Sends one byte over the loopback and checks every cycle of the frame
  // plus one idle bit period against the 8N1 frame model. A non-negative
  // inj injects send_en with 0x11 at that frame cycle.
  task automatic run_frame(input string tag, input logic [7:0] d,
                           input logic [2:0] b, input int inj);
    int         div, total;
    int         bad_line, bad_bps, bad_state, n_bps, n_done, done_at, n_rx, rx_at;
    logic [9:0] bits;
    logic [7:0] rx_got;
    logic       exp_line, exp_bps, exp_state;
    div  = ref_div(b);
    total = 11 * div;
    bits = {1'b1, d, 1'b0};
    bad_line = 0; bad_bps = 0; bad_state = 0; n_bps = 0;
    n_done = 0; done_at = -1; n_rx = 0; rx_at = -1; rx_got = '0;
    loop_en = 1'b1;
    @(negedge clk);
    data_byte = d;
    baud_set  = b;
    send_en   = 1'b1;
    @(negedge clk);
    send_en   = 1'b0;
    data_byte = 8'($urandom);
    for (int c = 1; c <= total; c++) begin
      // Changing baud_set mid-frame must affect neither side.
      if (c == 5) baud_set = 3'($urandom_range(0, 7));
      exp_line  = (c <= 10 * div) ? bits[(c - 1) / div] : 1'b1;
      exp_bps   = (c <= 10 * div) && (c % div == 0);
      exp_state = (c < 10 * div);
      if (rs232_tx !== exp_line)    bad_line++;
      if (bps_clk !== exp_bps)      bad_bps++;
      if (uart_state !== exp_state) bad_state++;
      if (bps_clk === 1'b1) n_bps++;
      if (tx_done === 1'b1) begin n_done++; done_at = c; end
      if (rx_done === 1'b1) begin n_rx++; rx_at = c; rx_got = rx_data_byte; end
      if (c == inj) begin
        send_en   = 1'b1;
        data_byte = 8'h11;
      end else if (c == inj + 1) begin
        send_en = 1'b0;
      end
      @(negedge clk);
    end
    model_rx = d;

    n_cmp++;
    if (bad_line !== 0) begin
      n_bad++; $display("FAIL %s tx_line: %0d bad cycles, want 0 (byte %h)", tag, bad_line, d);
    end
    n_cmp++;
    if (bad_bps !== 0) begin
      n_bad++; $display("FAIL %s bps_clk: %0d bad cycles, want 0", tag, bad_bps);
    end
    n_cmp++;
    if (bad_state !== 0) begin
      n_bad++; $display("FAIL %s uart_state: %0d bad cycles, want 0", tag, bad_state);
    end
    n_cmp++;
    if (n_bps !== 10) begin
      n_bad++; $display("FAIL %s bps_count: got %0d want 10", tag, n_bps);
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_bad++; $display("FAIL %s tx_done_count: got %0d want 1", tag, n_done);
    end
    n_cmp++;
    if (done_at !== 10 * div) begin
      n_bad++; $display("FAIL %s tx_done_latency: got %0d want %0d", tag, done_at, 10 * div);
    end
    n_cmp++;
    if (n_rx !== 1) begin
      n_bad++; $display("FAIL %s rx_done_count: got %0d want 1", tag, n_rx);
    end
    n_cmp++;
    if (rx_got !== d) begin
      n_bad++; $display("FAIL %s rx_byte: got %h want %h", tag, rx_got, d);
    end
    n_cmp++;
    if (rx_at <= 9 * div || rx_at > 10 * div) begin
      n_bad++; $display("FAIL %s rx_done_time: got cycle %0d want within stop bit %0d..%0d",
                        tag, rx_at, 9 * div + 1, 10 * div);
    end
    n_cmp++;
    if (rx_data_byte !== model_rx) begin
      n_bad++; $display("FAIL %s rx_hold: got %h want %h", tag, rx_data_byte, model_rx);
    end
  endtask

  // Drives one frame directly onto rs232_rx, then one idle period, and
  // reports how many rx_done pulses were seen and the last byte with one.
  task automatic drive_rx(input logic [7:0] d, input logic stop, input logic [2:0] b,
                          output int n_done, output logic [7:0] got);
    int         div;
    logic [9:0] bits;
    div    = ref_div(b);
    bits   = {stop, d, 1'b0};
    n_done = 0;
    got    = '0;
    loop_en  = 1'b0;
    baud_set = b;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < div; c++) begin
        rx_drive = bits[k];
        @(negedge clk);
        if (rx_done === 1'b1) begin n_done++; got = rx_data_byte; end
      end
    end
    rx_drive = 1'b1;
    for (int c = 0; c < 2 * div; c++) begin
      @(negedge clk);
      if (rx_done === 1'b1) begin n_done++; got = rx_data_byte; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_rx = 8'h00;
    n_cmp++;
    if (rs232_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", rs232_tx); end
    n_cmp++;
    if (tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_cmp++;
    if (uart_state !== 1'b0) begin n_bad++; $display("FAIL reset_state: got %b want 0", uart_state); end
    n_cmp++;
    if (bps_clk !== 1'b0) begin n_bad++; $display("FAIL reset_bps: got %b want 0", bps_clk); end
    n_cmp++;
    if (rx_data_byte !== model_rx) begin
      n_bad++; $display("FAIL reset_rx_data: got %h want %h", rx_data_byte, model_rx);
    end
    n_cmp++;
    if (rx_done !== 1'b0) begin n_bad++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
  endtask

  task automatic test_loopback();
    run_frame("loop_aa", 8'hAA, 3'd0, -1);
    repeat (100) @(negedge clk);
    run_frame("loop_e0", 8'hE0, 3'd0, -1);
    repeat (100) @(negedge clk);
    run_frame("loop_55", 8'h55, 3'd0, -1);
  endtask

  task automatic test_fast_baud();
    run_frame("fast_3c", 8'h3C, 3'd4, -1);
  endtask

  task automatic test_busy_ignore();
    run_frame("busy_a5", 8'hA5, 3'd0, 50);
  endtask

  task automatic test_glitch();
    int n_rx;
    loop_en  = 1'b0;
    rx_drive = 1'b1;
    baud_set = 3'd0;
    repeat (5) @(negedge clk);
    rx_drive = 1'b0;
    @(negedge clk);
    rx_drive = 1'b1;
    n_rx = 0;
    repeat (3 * ref_div(3'd0)) begin
      @(negedge clk);
      if (rx_done === 1'b1) n_rx++;
    end
    n_cmp++;
    if (n_rx !== 0) begin n_bad++; $display("FAIL glitch_rx_done: got %0d pulses want 0", n_rx); end
    n_cmp++;
    if (rx_data_byte !== model_rx) begin
      n_bad++; $display("FAIL glitch_rx_hold: got %h want %h", rx_data_byte, model_rx);
    end
  endtask

  task automatic test_framing_error();
    int         n_rx;
    logic [7:0] got;
    logic [7:0] d;
    logic [2:0] b;
    d = 8'($urandom);
    b = 3'($urandom_range(0, 4));
    drive_rx(d, 1'b0, b, n_rx, got);
    n_cmp++;
    if (n_rx !== 0) begin n_bad++; $display("FAIL framing_rx_done: got %0d pulses want 0", n_rx); end
    n_cmp++;
    if (rx_data_byte !== model_rx) begin
      n_bad++; $display("FAIL framing_rx_hold: got %h want %h", rx_data_byte, model_rx);
    end
    // A well-formed frame straight after must still be received.
    d = ~d;
    drive_rx(d, 1'b1, b, n_rx, got);
    model_rx = d;
    n_cmp++;
    if (n_rx !== 1) begin n_bad++; $display("FAIL recover_rx_done: got %0d pulses want 1", n_rx); end
    n_cmp++;
    if (got !== d) begin n_bad++; $display("FAIL recover_rx_byte: got %h want %h", got, d); end
  endtask

  task automatic test_reset_midframe();
    int div, n_done, n_rx;
    div = ref_div(3'd3);
    loop_en = 1'b1;
    @(negedge clk);
    data_byte = 8'hC3;
    baud_set  = 3'd3;
    send_en   = 1'b1;
    @(negedge clk);
    send_en = 1'b0;
    repeat (3 * div + 4) @(negedge clk);
    n_cmp++;
    if (uart_state !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b want 1", uart_state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rx = 8'h00;
    n_done = (tx_done === 1'b1) ? 1 : 0;
    n_rx   = (rx_done === 1'b1) ? 1 : 0;
    n_cmp++;
    if (rs232_tx !== 1'b1) begin n_bad++; $display("FAIL midrst_tx: got %b want 1", rs232_tx); end
    n_cmp++;
    if (uart_state !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got %b want 0", uart_state); end
    n_cmp++;
    if (rx_data_byte !== model_rx) begin
      n_bad++; $display("FAIL midrst_rx_data: got %h want %h", rx_data_byte, model_rx);
    end
    repeat (12 * div) begin
      @(negedge clk);
      if (tx_done === 1'b1) n_done++;
      if (rx_done === 1'b1) n_rx++;
    end
    n_cmp++;
    if (n_done !== 0) begin n_bad++; $display("FAIL midrst_tx_done: got %0d pulses want 0", n_done); end
    n_cmp++;
    if (n_rx !== 0) begin n_bad++; $display("FAIL midrst_rx_done: got %0d pulses want 0", n_rx); end
    run_frame("after_rst_5a", 8'h5A, 3'd3, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_frame("random", 8'($urandom), 3'($urandom_range(0, 7)), -1);
      repeat ($urandom_range(0, 50)) @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    baud_set  = 3'd0;
    data_byte = 8'h00;
    send_en   = 1'b0;
    loop_en   = 1'b1;
    rx_drive  = 1'b1;
    model_rx  = 8'h00;
    test_reset();
    test_loopback();
    test_fast_baud();
    test_busy_ignore();
    test_glitch();
    test_framing_error();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_rx.md
UART_TX_RX -- requirements
Module: uart_tx_rx

Interface
REQ-001 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose: clk  input  1  system clock, 50 MHz.
REQ-003 SHALL expose: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL expose: baud_set  input  3  shared TX/RX baud select.
REQ-005 SHALL expose: data_byte  input  8  TX payload, latched on accept.
REQ-006 SHALL expose: send_en  input  1  one-cycle TX start request.
REQ-007 SHALL expose: rs232_tx  output  1  serial TX line, idle high.
REQ-008 SHALL expose: tx_done  output  1  one-cycle pulse at frame end.
REQ-009 SHALL expose: uart_state  output  1  TX busy flag.
REQ-010 SHALL expose: bps_clk  output  1  one-cycle TX bit-tick pulse.
REQ-011 SHALL expose: rs232_rx  input  1  asynchronous serial RX line.
REQ-012 SHALL expose: rx_data_byte  output  8  last good received byte.
REQ-013 SHALL expose: rx_done  output  1  one-cycle pulse, byte valid.
REQ-014 SHALL use parameter CLK_FREQ, default 50_000_000, meaning clock frequency in Hz.

Function
REQ-015 baud_set SHALL map 0..4 to 9600/19200/38400/57600/115200 and 5..7 to 9600; bit period DIV = CLK_FREQ/baud, truncated (5208, 2604, 1302, 868, 434 at 50 MHz).
REQ-016 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-017 TX SHALL accept send_en only when uart_state=0; send_en while busy is ignored and does not alter data.
REQ-018 On accept in cycle N, TX SHALL latch data_byte; in cycle N+1 uart_state=1 and rs232_tx=0.
REQ-019 TX SHALL hold each of the 10 bits for exactly DIV cycles; a divider counting 0..DIV-1 runs only while busy.
REQ-020 bps_clk SHALL pulse for one cycle when the divider reaches DIV-1; 10 pulses per frame. It SHALL be 0 when idle.
REQ-021 On the 10th bps_clk (end of stop bit), tx_done=1 for one cycle and uart_state=0 in the same cycle; rs232_tx stays 1.
REQ-022 A new send_en SHALL be accepted from the cycle after tx_done.
REQ-023 baud_set SHALL be sampled at frame start (TX accept / RX start detect) and held for the frame.
REQ-024 RX SHALL pass rs232_rx through a 2-FF synchronizer; a 1->0 transition of the synchronized line while idle starts a frame.
REQ-025 RX SHALL sample each bit at mid-period using a 3-sample majority at offsets DIV/2-1, DIV/2 and DIV/2+1 from the bit start.
REQ-026 If the start-bit majority is 1, RX SHALL abort (false start) and return to idle with no rx_done.
REQ-027 If the stop-bit majority is 1, RX SHALL update rx_data_byte and pulse rx_done for one cycle in the cycle after the stop-bit decision.
REQ-028 If the stop-bit majority is 0 (framing error), RX SHALL drop the byte: no rx_done, rx_data_byte unchanged.
REQ-029 After the stop-bit decision, RX SHALL return to idle, ready for the next falling edge mid-stop-bit.
REQ-030 rx_data_byte SHALL hold its value between frames.
REQ-031 TX and RX SHALL operate independently and concurrently.

Reset
REQ-032 On rst=1: rs232_tx=1, tx_done=0, uart_state=0, bps_clk=0, rx_data_byte=0x00, rx_done=0, all counters 0, both FSMs idle.
REQ-033 Reset asserted mid-frame SHALL abort TX and RX immediately with no done pulse; the first frame after reset starts cleanly.

Verification
REQ-034 Loopback (rs232_rx=rs232_tx), baud_set=0: send 0xAA, then 0xE0, then 0x55, each 5000 cycles after the prior tx_done -> per frame 52080 cycles from accept to tx_done; rx_done with rx_data_byte = 0xAA, 0xE0, 0x55 respectively.
REQ-035 baud_set=4, send 0x3C -> each bit 434 cycles; 10 bps_clk pulses; loopback RX yields 0x3C.
REQ-036 send_en with 0x11 while busy sending 0xA5 -> ignored; only 0xA5 transmitted and received; one tx_done.
REQ-037 1-cycle low glitch on rs232_rx while idle -> no rx_done; rx_data_byte unchanged.
REQ-038 rst pulse during the data bits of a frame -> rs232_tx=1, uart_state=0 next cycle, no tx_done/rx_done; the next send of 0x5A loops back correctly.
REQ-039 Frame with stop bit forced 0 -> no rx_done; rx_data_byte keeps its previous value.
